poly_operand_driver: RTL

POLY_OPERAND_DRIVER -- requirements
Module: poly_operand_driver

---
 rtl/poly_operand_driver.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/poly_operand_driver.sv
`default_nettype none
// ============================================================================
// Module   : poly_operand_driver
// Brief    : Presents four latched operands (A, B, C, X) to a polynomial unit
//            using a go press/release strobe, then captures the unit's result.
//            Optional result-wait timeout: define POLY_DRV_TIMEOUT_EN to bound
//            the wait by TIMEOUT_CYCLES (timeout is tied 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module poly_operand_driver #(
  parameter int GO_HIGH_CYCLES = 2,
  parameter int GO_LOW_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [7:0] op_c,
  input  logic [7:0] op_x,
  output logic       ready,
  output logic       go,
  output logic [7:0] data_out,
  input  logic [7:0] result_in,
  input  logic       result_valid_in,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       timeout
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_SETUP    = 3'd1;
  localparam logic [2:0] c_PRESS    = 3'd2;
  localparam logic [2:0] c_RELEASE  = 3'd3;
  localparam logic [2:0] c_WAIT_RES = 3'd4;

  // Phase counters run 0..N-1 and the state advances on the last count.
  localparam logic [3:0] c_HIGH_LAST = 4'(GO_HIGH_CYCLES - 1);
  localparam logic [3:0] c_LOW_LAST  = 4'(GO_LOW_CYCLES - 1);
  localparam logic [1:0] c_IDX_LAST  = 2'd3;

  // Reject out-of-range configurations at elaboration.
  if (GO_HIGH_CYCLES < 1 || GO_HIGH_CYCLES > 15 ||
      GO_LOW_CYCLES  < 1 || GO_LOW_CYCLES  > 15 ||
      TIMEOUT_CYCLES < 8 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("poly_operand_driver: parameter out of legal range");
  end

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][7:0]  ops_q, ops_d;     // [0]=A, [1]=B, [2]=C, [3]=X
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       result_q, result_d;
  logic             rv_q, rv_d;

`ifdef POLY_DRV_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]       wait_q, wait_d;
  logic             to_q, to_d;
`endif

  // Next-state and datapath decode for the operand sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ops_d    = ops_q;
    dout_d   = dout_q;
    result_d = result_q;
    rv_d     = 1'b0;
`ifdef POLY_DRV_TIMEOUT_EN
    wait_d   = wait_q;
    to_d     = 1'b0;
`endif
    case (state_q)
      c_IDLE: begin
        if (start) begin
          // Operands are sampled only here, so op_* may change freely mid-run.
          ops_d   = {op_x, op_c, op_b, op_a};
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          dout_d  = op_a;
          state_d = c_SETUP;
        end
      end
      c_SETUP: begin
        cnt_d   = 4'd0;
        state_d = c_PRESS;
      end
      c_PRESS: begin
        if (cnt_q == c_HIGH_LAST) begin
          cnt_d   = 4'd0;
          state_d = c_RELEASE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      c_RELEASE: begin
        if (cnt_q == c_LOW_LAST) begin
          cnt_d = 4'd0;
          if (idx_q == c_IDX_LAST) begin
            state_d = c_WAIT_RES;
`ifdef POLY_DRV_TIMEOUT_EN
            wait_d  = 8'd0;
`endif
          end else begin
            // Load the next operand now so it is stable for the whole SETUP cycle.
            idx_d   = idx_q + 2'd1;
            dout_d  = ops_q[idx_q + 2'd1];
            state_d = c_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      c_WAIT_RES: begin
        // Capture has priority over a timeout expiring in the same cycle.
        if (result_valid_in) begin
          result_d = result_in;
          rv_d     = 1'b1;
          state_d  = c_IDLE;
`ifdef POLY_DRV_TIMEOUT_EN
          wait_d   = 8'd0;
        end else if (wait_q == c_TO_LAST) begin
          to_d     = 1'b1;
          wait_d   = 8'd0;
          state_d  = c_IDLE;
        end else begin
          wait_d   = wait_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= 2'd0;
      ops_q    <= '0;
      dout_q   <= 8'd0;
      result_q <= 8'd0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ops_q    <= ops_d;
      dout_q   <= dout_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

`ifdef POLY_DRV_TIMEOUT_EN
  // Result-wait counter and timeout pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= 8'd0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign ready        = (state_q == c_IDLE);
  assign go           = (state_q == c_PRESS);
  assign data_out     = dout_q;
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule
`default_nettype wire
